// File: rtl/nsum_sched_pkg.sv
// Shared types and default sizes for the NSum scheduler.
// State encoding plus width/timeout defaults used by the interface and top.
package nsum_sched_pkg;
    localparam int NREQ_DEF    = 4;
    localparam int N_W_DEF     = 3;
    localparam int SUM_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {IDLE, DISPATCH, WAIT, RESP} state_t;
endpackage

// File: rtl/nsum_sched_if.sv
// Requester and engine bundle for nsum_sched; master = clients/engine side, slave = scheduler.
// req_n packs requester k at bits [k*N_W +: N_W]; rsp_sum is shared, qualified by one-hot rsp_valid.
interface nsum_sched_if
    import nsum_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int N_W   = N_W_DEF,
    parameter int SUM_W = SUM_W_DEF
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*N_W-1:0] req_n;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [SUM_W-1:0]    rsp_sum;
    logic                rsp_err;
    logic [NREQ-1:0]     rsp_ready;
    logic [N_W-1:0]      eng_n;
    logic                eng_n_valid;
    logic                eng_reset;
    logic [SUM_W-1:0]    eng_sum;
    logic                eng_sum_valid;

    modport master (
        output req_valid, req_n, rsp_ready, eng_sum, eng_sum_valid,
        input  req_ready, rsp_valid, rsp_sum, rsp_err, eng_n, eng_n_valid, eng_reset
    );

    modport slave (
        input  req_valid, req_n, rsp_ready, eng_sum, eng_sum_valid,
        output req_ready, rsp_valid, rsp_sum, rsp_err, eng_n, eng_n_valid, eng_reset
    );
endinterface

// File: rtl/nsum_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping; combinational.
// Produces one-hot grant, its index, and an any-request flag.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    int k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/nsum_sched.sv
// Shares one NSum engine among NREQ requesters: accept (comb ready) -> dispatch -> wait -> respond; N>=1 responds A+N+3, N=0 A+1.
// Response held until owner's rsp_ready; optional engine watchdog under NSUM_SCHED_TIMEOUT_EN.
module nsum_sched
    import nsum_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int N_W   = N_W_DEF,
    parameter int SUM_W = SUM_W_DEF
`ifdef NSUM_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input logic         clk,
    input logic         reset,
    nsum_sched_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] g_idx;
    logic [IDX_W-1:0] next_ptr;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  owner_oh;
    logic [NREQ-1:0]  rsp_valid_q;
    logic             any_req;
    logic [N_W-1:0]   g_n;
    logic [N_W-1:0]   eng_n_q;
    logic             eng_n_valid_q;
    logic [SUM_W-1:0] rsp_sum_q;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (g_idx),
        .any   (any_req)
    );

    assign g_n      = bus.req_n[int'(g_idx)*N_W +: N_W];
    assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner;
    assign next_ptr = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;

    assign bus.req_ready   = (state == IDLE && !reset) ? grant : '0;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_sum     = rsp_sum_q;
    assign bus.eng_n       = eng_n_q;
    assign bus.eng_n_valid = eng_n_valid_q;

`ifdef NSUM_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_pulse;
    logic            err_q;

    assign bus.eng_reset = reset | to_pulse;
    assign bus.rsp_err   = err_q;
`else
    assign bus.eng_reset = reset;
    assign bus.rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            rsp_valid_q   <= '0;
            rsp_sum_q     <= '0;
            eng_n_q       <= '0;
            eng_n_valid_q <= 1'b0;
`ifdef NSUM_SCHED_TIMEOUT_EN
            to_cnt        <= '0;
            to_pulse      <= 1'b0;
            err_q         <= 1'b0;
`endif
        end else begin
`ifdef NSUM_SCHED_TIMEOUT_EN
            to_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= g_idx;
                        // The engine never terminates for N=0, so answer it directly.
                        if (g_n == '0) begin
                            state       <= RESP;
                            rsp_valid_q <= grant;
                            rsp_sum_q   <= '0;
`ifdef NSUM_SCHED_TIMEOUT_EN
                            err_q       <= 1'b0;
`endif
                        end else begin
                            state         <= DISPATCH;
                            eng_n_q       <= g_n;
                            eng_n_valid_q <= 1'b1;
                        end
                    end
                end
                DISPATCH: begin
                    // Engine reloads N every idle cycle; N must return to 0 after the start pulse.
                    state         <= WAIT;
                    eng_n_q       <= '0;
                    eng_n_valid_q <= 1'b0;
`ifdef NSUM_SCHED_TIMEOUT_EN
                    to_cnt        <= '0;
`endif
                end
                WAIT: begin
                    if (bus.eng_sum_valid) begin
                        state       <= RESP;
                        rsp_valid_q <= owner_oh;
                        rsp_sum_q   <= bus.eng_sum;
`ifdef NSUM_SCHED_TIMEOUT_EN
                        err_q       <= 1'b0;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        state       <= RESP;
                        rsp_valid_q <= owner_oh;
                        rsp_sum_q   <= '0;
                        err_q       <= 1'b1;
                        to_pulse    <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[owner]) begin
                        state       <= IDLE;
                        rsp_valid_q <= '0;
                        rr_ptr      <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nsum_sched.sv
// Randomized and directed bench for nsum_sched with an engine model and queue scoreboard.
module tb_nsum_sched;
    import nsum_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int N_W   = 3;
    localparam int SUM_W = 4;
    localparam int BIG   = 1 << 30;
`ifdef NSUM_SCHED_TIMEOUT_EN
    localparam int TIMEOUT = TIMEOUT_DEF;
`endif

    typedef struct {
        int owner;
        int sum;
        int err;
        int first;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t sb[$];
    int   served[$];
    int   free_from = 0;
    int   m_rr = 0;
    int   disp_cyc = -1;
    int   disp_n = 0;
    int   to_cyc = -1;
    bit   chk_en = 1'b0;

    logic [NREQ-1:0] acc_q = '0;
    int   rsp_mode = 1;
    bit   spur_en = 1'b0;
    bit   eng_dead = 1'b0;
    int   eng_cd = 0;
    int   eng_lat_n = 0;

    nsum_sched_if #(.NREQ(NREQ), .N_W(N_W), .SUM_W(SUM_W)) bus ();

    nsum_sched #(.NREQ(NREQ), .N_W(N_W), .SUM_W(SUM_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Engine model: start pulse seen in cycle D -> sum_valid in cycle D+N+1.
    always @(negedge clk) begin
        if (bus.eng_reset) eng_cd = 0;
        else if (bus.eng_n_valid && !eng_dead) begin
            eng_cd    = int'(bus.eng_n) + 1;
            eng_lat_n = int'(bus.eng_n);
        end
    end

    always @(posedge clk) begin
        logic [SUM_W-1:0] acc;
        #1;
        bus.eng_sum_valid = 1'b0;
        bus.eng_sum       = SUM_W'($urandom);
        if (eng_cd > 0) begin
            eng_cd = eng_cd - 1;
            if (eng_cd == 0) begin
                acc = '0;
                for (int i = 1; i <= eng_lat_n; i++) acc = acc + SUM_W'(i);
                bus.eng_sum_valid = 1'b1;
                bus.eng_sum       = acc;
            end
        end else if (spur_en && !eng_dead && $urandom_range(0, 7) == 0) begin
            bus.eng_sum_valid = 1'b1;
        end
    end

    always @(negedge clk) acc_q = bus.req_valid & bus.req_ready;

    // Reference model: grant order, dispatch timing, expected responses.
    always @(negedge clk) begin
        int g;
        int k;
        int n;
        int s;
        int e;
        int f;
        logic [NREQ-1:0] exp_rdy;
        if (chk_en) begin
            if (reset) begin
                check("eng_reset_in_reset", bus.eng_reset, 1);
                check("req_ready_in_reset", bus.req_ready, 0);
                sb.delete();
                free_from = cyc + 1;
                m_rr      = 0;
                disp_cyc  = -1;
                to_cyc    = -1;
            end else begin
                g = -1;
                exp_rdy = '0;
                if (cyc >= free_from) begin
                    for (int i = 0; i < NREQ; i++) begin
                        k = (m_rr + i) % NREQ;
                        if (g < 0 && bus.req_valid[k]) g = k;
                    end
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
                check("req_ready", bus.req_ready, exp_rdy);
                check("eng_n_valid", bus.eng_n_valid, (cyc == disp_cyc) ? 1 : 0);
                check("eng_n", bus.eng_n, (cyc == disp_cyc) ? disp_n : 0);
                check("eng_reset", bus.eng_reset, (cyc == to_cyc) ? 1 : 0);
                if (g >= 0) begin
                    n = int'(bus.req_n[g*N_W +: N_W]);
                    s = (n * (n + 1) / 2) % (1 << SUM_W);
                    e = 0;
                    if (n == 0) begin
                        f = cyc + 1;
                    end else begin
                        disp_cyc = cyc + 1;
                        disp_n   = n;
                        f        = cyc + n + 3;
`ifdef NSUM_SCHED_TIMEOUT_EN
                        if (eng_dead) begin
                            f      = cyc + 2 + TIMEOUT;
                            s      = 0;
                            e      = 1;
                            to_cyc = f;
                        end
`endif
                    end
                    sb.push_back('{owner: g, sum: s, err: e, first: f});
                    free_from = BIG;
                end
            end
        end
    end

    // Monitor: compares presented responses against the scoreboard head.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_v;
        if (chk_en && !reset) begin
            if (sb.size() > 0 && cyc >= sb[0].first) begin
                exp_v = '0;
                exp_v[sb[0].owner] = 1'b1;
                check("rsp_valid", bus.rsp_valid, exp_v);
                check("rsp_sum", bus.rsp_sum, sb[0].sum);
                check("rsp_err", bus.rsp_err, sb[0].err);
                if (bus.rsp_ready[sb[0].owner]) begin
                    m_rr      = (sb[0].owner + 1) % NREQ;
                    free_from = cyc + 1;
                    served.push_back(sb[0].owner);
                    void'(sb.pop_front());
                end
            end else begin
                check("rsp_valid_idle", bus.rsp_valid, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++)
            if (acc_q[k]) bus.req_valid[k] = 1'b0;
        case (rsp_mode)
            0:       bus.rsp_ready = '0;
            1:       bus.rsp_ready = '1;
            default: bus.rsp_ready = NREQ'($urandom);
        endcase
    endtask

    task automatic issue(input int k, input int n);
        bus.req_valid[k]            = 1'b1;
        bus.req_n[k*N_W +: N_W]     = n[N_W-1:0];
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while ((sb.size() != 0 || bus.req_valid != '0) && i < budget) begin
            step();
            i++;
        end
        check("drain", (sb.size() == 0 && bus.req_valid == '0) ? 1 : 0, 1);
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_order[4];
        bus.req_valid     = '0;
        bus.req_n         = '0;
        bus.rsp_ready     = '1;
        bus.eng_sum       = '0;
        bus.eng_sum_valid = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_sum", bus.rsp_sum, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_eng_n", bus.eng_n, 0);
        check("rst_eng_n_valid", bus.eng_n_valid, 0);
        check("rst_eng_reset", bus.eng_reset, 0);
        chk_en = 1'b1;

        // Simultaneous requests from pointer 0.
        step();
        served.delete();
        issue(0, 1); issue(1, 2); issue(2, 3); issue(3, 5);
        drain(100);
        exp_order = '{0, 1, 2, 3};
        for (int i = 0; i < 4; i++)
            check("served_order", (served.size() > i) ? served[i] : -1, exp_order[i]);

        // Single request, N=4.
        issue(0, 4);
        drain(40);

        // N=0 bypasses the engine.
        issue(2, 0);
        drain(20);

        // N=7 with response held off while another requester waits.
        rsp_mode = 0;
        step();
        issue(1, 7);
        for (int i = 0; i < 40 && bus.rsp_valid == '0; i++) step();
        check("hold_rsp_seen", (bus.rsp_valid != '0) ? 1 : 0, 1);
        issue(3, 2);
        repeat (5) step();
        check("hold_rsp_sum", bus.rsp_sum, 12);
        rsp_mode = 1;
        drain(60);

        // Reset while waiting on the engine.
        issue(1, 5);
        drain(40);
        issue(2, 7);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_rsp_valid", bus.rsp_valid, 0);
        check("post_rst_rsp_sum", bus.rsp_sum, 0);
        check("post_rst_eng_n_valid", bus.eng_n_valid, 0);
        step();
        issue(0, $urandom_range(0, 7)); issue(1, $urandom_range(0, 7));
        issue(2, $urandom_range(0, 7)); issue(3, $urandom_range(0, 7));
        drain(100);

`ifdef NSUM_SCHED_TIMEOUT_EN
        eng_dead = 1'b1;
        issue(0, 3);
        drain(60);
        eng_dead = 1'b0;
`endif

        // Randomized traffic with spurious engine pulses outside WAIT.
        spur_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) rsp_mode = $urandom_range(1, 2);
            for (int k = 0; k < NREQ; k++)
                if (!bus.req_valid[k] && $urandom_range(0, 3) == 0)
                    issue(k, $urandom_range(0, 7));
            step();
        end
        spur_en  = 1'b0;
        rsp_mode = 1;
        drain(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/nsum_sched.md
# nsum_sched

Round-robin scheduler that shares one NSum engine (sum 1..N, 3-bit N, 4-bit sum) among NREQ requesters. It accepts one request at a time over per-requester valid/ready, dispatches N to the engine, waits for the engine's sum_valid, and returns the result to the owning requester over a response handshake. It sits between the requester clients and the single engine instance and owns the engine's N/N_valid/reset inputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- N_W, 3, width of N
- SUM_W, 4, width of sum
- TIMEOUT, 16, engine watchdog limit in cycles (only with NSUM_SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  request present, per requester
- req_n  in  NREQ*N_W  N per requester, requester k at bits [k*N_W +: N_W]
- req_ready  out  NREQ  one-hot accept
- rsp_valid  out  NREQ  one-hot response valid
- rsp_sum  out  SUM_W  response sum (shared bus)
- rsp_err  out  1  response is a timeout error
- rsp_ready  in  NREQ  response accepted, per requester
- eng_n  out  N_W  engine N
- eng_n_valid  out  1  engine start
- eng_reset  out  1  engine reset
- eng_sum  in  SUM_W  engine sum
- eng_sum_valid  in  1  engine result qualifier

## Operation
- FSM states: IDLE, DISPATCH, WAIT, RESP.
- IDLE: grant g = first k with req_valid[k], searching from rr pointer upward with wrap. If any valid: req_ready[g]=1 this cycle (combinational), latch owner=g and N=req_n[g]. If N==0 go RESP with sum 0 (engine never dispatched; it does not terminate for N=0); else go DISPATCH.
- DISPATCH: eng_n=N, eng_n_valid=1 for exactly this cycle -> WAIT.
- WAIT: on eng_sum_valid capture eng_sum -> RESP. eng_sum_valid outside WAIT is ignored.
- RESP: rsp_valid[owner]=1, rsp_sum/rsp_err stable until rsp_ready[owner]; on that cycle rr pointer <= owner+1 mod NREQ, -> IDLE. rsp_ready of other requesters ignored.
- eng_n=0 and eng_n_valid=0 in every state except DISPATCH (engine in idle reloads N every cycle; a nonzero N would fake a sum_valid).
- Arithmetic: sum passed through unmodified; engine wraps modulo 2^SUM_W (N=6 -> 5, N=7 -> 12). No overflow flag.
- req_ready all 0 outside IDLE; requests held by clients meanwhile.
- eng_reset = reset (plus timeout pulse, see Configuration).

## Timing
- Reset values: state IDLE, rr pointer 0, req_ready 0, rsp_valid 0, rsp_sum 0, rsp_err 0, eng_n 0, eng_n_valid 0.
- Accept in cycle A (N>=1): DISPATCH A+1, eng_sum_valid in A+N+2, rsp_valid from A+N+3.
- N=0: rsp_valid from A+1.
- Back-to-back: earliest next accept is the cycle after rsp_ready handshake.
- Reset mid-operation: all state to reset values next edge; in-flight request dropped without response; engine reset in same cycle.
- Simultaneous requests: one grant per IDLE cycle by pointer order; fairness: every continuously-valid requester served within NREQ transactions.

## Configuration
- NSUM_SCHED_TIMEOUT_EN defined: cycle counter cleared on DISPATCH, counts in WAIT; on reaching TIMEOUT with no eng_sum_valid, eng_reset pulses 1 cycle, RESP entered with rsp_err=1, rsp_sum=0.
- Undefined: no counter, WAIT waits indefinitely, rsp_err tied 0, eng_reset = reset.

## Structure
- Package nsum_sched_pkg: state enum (IDLE, DISPATCH, WAIT, RESP), default widths N_W/SUM_W, TIMEOUT default.
- Sub-module rr_arbiter: NREQ-wide request vector + pointer -> one-hot grant and index; purely combinational, pointer kept in nsum_sched.

## Test plan
- Single request k=0, N=4 accepted in cycle A -> eng_n_valid in A+1, rsp_valid[0] from A+7, rsp_sum=10, rsp_err=0.
- All 4 requesters valid, N=1,2,3,5 -> served order 0,1,2,3, sums 1,3,6,15; then pointer 0 again.
- N=0 from requester 2 -> no eng_n_valid, rsp_valid[2] next cycle, rsp_sum=0.
- N=7 -> rsp_sum=12; rsp_ready held low 5 cycles -> rsp_valid/rsp_sum stable, no new req_ready.
- reset asserted in WAIT -> next cycle all outputs at reset values, pointer 0, no response issued.
- With NSUM_SCHED_TIMEOUT_EN, engine model never asserts sum_valid -> eng_reset pulse after 16 WAIT cycles, rsp_err=1, rsp_sum=0.
